// File: rtl/instr_decode_pipe_pkg.sv
// Shared constants for the instruction decode pipeline: mode codes, opcode
// codes, ALU operation codes, FSM state encoding and instruction field macros.
// Optional feature macro used by the design: INSTR_DECODE_ILLEGAL_TRAP_EN.

`ifndef INSTR_DECODE_PIPE_PKG_SV
`define INSTR_DECODE_PIPE_PKG_SV

// Field extraction in terms of the word width (IW) and register address width (RW)
`define IDP_MODE(word, IW)   word[(IW)-1 -: 2]
`define IDP_OPCODE(word, IW) word[(IW)-3 -: 4]
`define IDP_R1(word, RW)     word[2*(RW)-1 -: (RW)]
`define IDP_R2(word, RW)     word[(RW)-1:0]

package instr_decode_pipe_pkg;

  // Instruction modes
  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_DAT = 2'b01;

  // Register-mode opcodes
  localparam logic [3:0] OP_SHOWR = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;

  // Data-mode opcodes
  localparam logic [3:0] OP_LDI   = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;

  // ALU operation codes (zero-extended to ALUOP_W at the ports)
  localparam logic [2:0] ALU_PD1  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_PIMM = 3'd5;

  // Decoder FSM: waiting for an opcode word, or for the immediate of a DAT instruction
  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

endpackage

`endif

// File: rtl/instr_field_decode.sv
// Purely combinational mode/opcode decoder producing the control part of a
// decoded bundle. Words that are not legal instructions decode as a PD1
// no-op with o_Illegal set.

module instr_field_decode
  import instr_decode_pipe_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [1:0]         i_Mode,
  input  logic [3:0]         i_Opcode,
  output logic [ALUOP_W-1:0] o_ALUOp,
  output logic               o_WriteBack,
  output logic               o_ShowR1,
  output logic               o_UseImm,
  output logic               o_Illegal
);

  logic [2:0] w_alu;

  // Map mode/opcode to control signals; anything unlisted is illegal
  always_comb begin
    w_alu       = ALU_PD1;
    o_WriteBack = 1'b0;
    o_ShowR1    = 1'b0;
    o_UseImm    = 1'b0;
    o_Illegal   = 1'b0;
    case (i_Mode)
      MODE_REG: begin
        case (i_Opcode)
          OP_SHOWR: begin w_alu = ALU_PD1; o_ShowR1    = 1'b1; end
          OP_ADD:   begin w_alu = ALU_ADD; o_WriteBack = 1'b1; end
          OP_SUB:   begin w_alu = ALU_SUB; o_WriteBack = 1'b1; end
          OP_AND:   begin w_alu = ALU_AND; o_WriteBack = 1'b1; end
          OP_OR:    begin w_alu = ALU_OR;  o_WriteBack = 1'b1; end
          default:  o_Illegal = 1'b1;
        endcase
      end
      MODE_DAT: begin
        case (i_Opcode)
          OP_LDI:  begin w_alu = ALU_PIMM; o_WriteBack = 1'b1; o_UseImm = 1'b1; end
          OP_ADDI: begin w_alu = ALU_ADD;  o_WriteBack = 1'b1; o_UseImm = 1'b1; end
          default: o_Illegal = 1'b1;
        endcase
      end
      default: o_Illegal = 1'b1;
    endcase
  end

  assign o_ALUOp = ALUOP_W'(w_alu);

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered valid/ready instruction decoder. REG words decode in one beat;
// DAT words hold their opcode/registers until the following immediate word.
// Optional feature: define INSTR_DECODE_ILLEGAL_TRAP_EN to emit flagged
// bundles for illegal words and count them (o_Illegal, o_IllegalCnt).

module instr_decode_pipe
  import instr_decode_pipe_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int RADDR_W = 3,
  parameter int ALUOP_W = 4
) (
  input  logic               i_CLK,
  input  logic               i_RSTn,
  input  logic [INSTR_W-1:0] i_Instr,
  input  logic               i_InstrValid,
  output logic               o_InstrReady,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [RADDR_W-1:0] o_AddrReg1,
  output logic [RADDR_W-1:0] o_AddrReg2,
  output logic [ALUOP_W-1:0] o_ALUOp,
  output logic               o_WriteBack,
  output logic               o_ShowR1,
  output logic               o_UseImm,
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
  output logic               o_Illegal,
  output logic [7:0]         o_IllegalCnt,
`endif
  output logic [INSTR_W-1:0] o_Imm
);

  state_t r_state, w_state_nxt;

  logic [3:0]         r_hold_op;
  logic [RADDR_W-1:0] r_hold_r1, r_hold_r2;

  logic               r_valid, r_wb, r_show, r_useimm;
  logic [RADDR_W-1:0] r_a1, r_a2;
  logic [ALUOP_W-1:0] r_alu;
  logic [INSTR_W-1:0] r_imm;

  logic               w_in_fire, w_out_fire, w_load, w_hold_en;
  logic [1:0]         w_dec_mode;
  logic [3:0]         w_dec_op;
  logic [ALUOP_W-1:0] w_dec_alu;
  logic               w_dec_wb, w_dec_show, w_dec_useimm, w_dec_illegal;

  assign o_InstrReady = !r_valid || i_Ready;
  assign w_in_fire    = i_InstrValid && o_InstrReady;
  assign w_out_fire   = r_valid && i_Ready;

  // In S_IMM the control fields come from the held DAT opcode, not the incoming word
  assign w_dec_mode = (r_state == S_IMM) ? MODE_DAT  : `IDP_MODE(i_Instr, INSTR_W);
  assign w_dec_op   = (r_state == S_IMM) ? r_hold_op : `IDP_OPCODE(i_Instr, INSTR_W);

  instr_field_decode #(.ALUOP_W(ALUOP_W)) u_field_decode (
    .i_Mode      (w_dec_mode),
    .i_Opcode    (w_dec_op),
    .o_ALUOp     (w_dec_alu),
    .o_WriteBack (w_dec_wb),
    .o_ShowR1    (w_dec_show),
    .o_UseImm    (w_dec_useimm),
    .o_Illegal   (w_dec_illegal)
  );

  // Next-state, output-register load and DAT holding-register capture decisions
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_hold_en   = 1'b0;
    if (w_in_fire) begin
      if (r_state == S_IMM) begin
        w_load      = 1'b1;
        w_state_nxt = S_OP;
      end else if (w_dec_illegal) begin
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
        w_load = 1'b1;
`else
        w_load = 1'b0;
`endif
      end else if (w_dec_mode == MODE_DAT) begin
        w_hold_en   = 1'b1;
        w_state_nxt = S_IMM;
      end else begin
        w_load = 1'b1;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state register
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) r_state <= S_OP;
    else         r_state <= w_state_nxt;
  end

  // Capture opcode and register fields of a DAT word while its immediate is awaited
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_hold_op <= 4'd0;
      r_hold_r1 <= '0;
      r_hold_r2 <= '0;
    end else if (w_hold_en) begin
      r_hold_op <= `IDP_OPCODE(i_Instr, INSTR_W);
      r_hold_r1 <= `IDP_R1(i_Instr, RADDR_W);
      r_hold_r2 <= `IDP_R2(i_Instr, RADDR_W);
    end
  end

  // Output bundle register: load a new bundle (possibly while draining), else clear valid on drain
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_valid  <= 1'b0;
      r_alu    <= '0;
      r_wb     <= 1'b0;
      r_show   <= 1'b0;
      r_useimm <= 1'b0;
      r_a1     <= '0;
      r_a2     <= '0;
      r_imm    <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_alu    <= w_dec_alu;
      r_wb     <= w_dec_wb;
      r_show   <= w_dec_show;
      r_useimm <= w_dec_useimm;
      r_a1     <= (r_state == S_IMM) ? r_hold_r1 : `IDP_R1(i_Instr, RADDR_W);
      r_a2     <= (r_state == S_IMM) ? r_hold_r2 : `IDP_R2(i_Instr, RADDR_W);
      r_imm    <= (r_state == S_IMM) ? i_Instr : '0;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
  logic       r_illegal;
  logic [7:0] r_ill_cnt;

  // Illegal flag travels with the bundle; the counter saturates at 255
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_illegal <= 1'b0;
      r_ill_cnt <= 8'd0;
    end else if (w_load) begin
      r_illegal <= w_dec_illegal;
      if (w_dec_illegal && (r_ill_cnt != 8'hFF)) r_ill_cnt <= r_ill_cnt + 8'd1;
    end
  end

  assign o_Illegal    = r_illegal;
  assign o_IllegalCnt = r_ill_cnt;
`endif

  assign o_Valid     = r_valid;
  assign o_ALUOp     = r_alu;
  assign o_WriteBack = r_wb;
  assign o_ShowR1    = r_show;
  assign o_UseImm    = r_useimm;
  assign o_AddrReg1  = r_a1;
  assign o_AddrReg2  = r_a2;
  assign o_Imm       = r_imm;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe: the reference model turns every
// accepted word into an expected bundle; a monitor pops and compares on each
// output transfer. Build with +define+INSTR_DECODE_ILLEGAL_TRAP_EN to cover
// the illegal-trap variant.

module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_Instr = 16'h0000;
  logic        i_InstrValid = 1'b0;
  logic        i_Ready;
  logic        o_InstrReady, o_Valid, o_WriteBack, o_ShowR1, o_UseImm;
  logic [2:0]  o_AddrReg1, o_AddrReg2;
  logic [3:0]  o_ALUOp;
  logic [15:0] o_Imm;
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
  logic        o_Illegal;
  logic [7:0]  o_IllegalCnt;
`endif

  always #5 clk = ~clk;

  instr_decode_pipe dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_Instr(i_Instr), .i_InstrValid(i_InstrValid),
    .o_InstrReady(o_InstrReady), .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_AddrReg1(o_AddrReg1), .o_AddrReg2(o_AddrReg2), .o_ALUOp(o_ALUOp),
    .o_WriteBack(o_WriteBack), .o_ShowR1(o_ShowR1), .o_UseImm(o_UseImm),
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    .o_Illegal(o_Illegal), .o_IllegalCnt(o_IllegalCnt),
`endif
    .o_Imm(o_Imm)
  );

  typedef struct packed {
    logic        ill;
    logic [7:0]  cnt;
    logic [3:0]  alu;
    logic        wb;
    logic        show;
    logic        ui;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [15:0] imm;
  } bundle_t;

  bundle_t     exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  // reference model state
  bit          pend = 1'b0;
  int          pend_op;
  logic [2:0]  pend_a1, pend_a2;
  int          ill_cnt = 0;
  // ready generator control
  bit          rdy_rand = 1'b0;
  logic        rdy_val  = 1'b1;

  function automatic bundle_t cur_out();
    bundle_t b;
    b = '0;
    b.alu = o_ALUOp; b.wb = o_WriteBack; b.show = o_ShowR1; b.ui = o_UseImm;
    b.a1 = o_AddrReg1; b.a2 = o_AddrReg2; b.imm = o_Imm;
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    b.ill = o_Illegal; b.cnt = o_IllegalCnt;
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what one accepted word means under the instruction set rules
  task automatic model_accept(input logic [15:0] w);
    int      mode;
    int      op;
    bundle_t b;
    mode = int'(w[15:14]);
    op   = int'(w[13:10]);
    b    = '0;
    if (pend) begin
      b.alu = (pend_op == 0) ? 4'd5 : 4'd1;
      b.wb = 1'b1; b.ui = 1'b1; b.imm = w;
      b.a1 = pend_a1; b.a2 = pend_a2; b.cnt = 8'(ill_cnt);
      exp_q.push_back(b);
      pend = 1'b0;
    end else if (mode == 0 && op <= 4) begin
      b.alu = 4'(op); b.show = (op == 0); b.wb = (op != 0);
      b.a1 = w[5:3]; b.a2 = w[2:0]; b.cnt = 8'(ill_cnt);
      exp_q.push_back(b);
    end else if (mode == 1 && op <= 1) begin
      pend = 1'b1; pend_op = op; pend_a1 = w[5:3]; pend_a2 = w[2:0];
    end else begin
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
      if (ill_cnt < 255) ill_cnt++;
      b.ill = 1'b1; b.alu = 4'd0;
      b.a1 = w[5:3]; b.a2 = w[2:0]; b.cnt = 8'(ill_cnt);
      exp_q.push_back(b);
`endif
    end
  endtask

  // Present one word until accepted; returns the number of cycles it waited
  task automatic send(input logic [15:0] w, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    i_Instr = w;
    i_InstrValid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = o_InstrReady;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: word 0x%0h not accepted after %0d cycles", w, waited);
    end else begin
      model_accept(w);
    end
    i_InstrValid = 1'b0;
    i_Instr = 16'($urandom);
  endtask

  // Consumer ready generator
  initial begin
    i_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      i_Ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: handshake rule, hold-stability under stall, scoreboard pop on transfer
  initial begin
    bundle_t cur, prev_b, e;
    bit      stall_prev;
    stall_prev = 1'b0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        cur = cur_out();
        check("instr_ready_rule", 64'(o_InstrReady), 64'(!o_Valid || i_Ready));
        if (stall_prev) check("stall_hold", {o_Valid, cur}, {1'b1, prev_b});
        if (o_Valid && i_Ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_bundle: got 0x%0h, expected none", cur);
          end else begin
            e = exp_q.pop_front();
            check("bundle", 64'(cur), 64'(e));
          end
        end
        stall_prev = o_Valid && !i_Ready;
        prev_b = cur;
      end
    end
  end

  initial begin
    int waited;
    int r;
    logic [15:0] w;

    // Reset state
    #1;
    check("reset_outputs", {o_Valid, cur_out()}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // REG ADD R1=2 R2=5: latency one
    send(16'h0415, waited);
    check("add_valid", 64'(o_Valid), 64'd1);
    check("add_fields", {o_ALUOp, o_WriteBack, o_AddrReg1, o_AddrReg2, o_UseImm},
          {4'd1, 1'b1, 3'd2, 3'd5, 1'b0});

    // DAT LDI R1=3 then immediate 0xBEEF
    send(16'h4018, waited);
    check("ldi_first_beat_no_valid", 64'(o_Valid), 64'd0);
    send(16'hBEEF, waited);
    check("ldi_bundle", {o_Valid, o_ALUOp, o_UseImm, o_WriteBack, o_Imm},
          {1'b1, 4'd5, 1'b1, 1'b1, 16'hBEEF});

    // Back-to-back SHOWR stream: one word per cycle
    for (int i = 0; i < 6; i++) begin
      send({10'd0, 6'($urandom)}, waited);
      check("showr_throughput", {64'(waited), 1'b0, o_Valid, o_ShowR1, o_WriteBack},
            {64'd1, 1'b0, 1'b1, 1'b1, 1'b0});
    end

    // Stall three cycles while a SUB bundle is held, then resume
    send(16'h0813, waited);
    rdy_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_outputs", {o_InstrReady, o_Valid, o_ALUOp, o_AddrReg1, o_AddrReg2},
            {1'b0, 1'b1, 4'd2, 3'd2, 3'd3});
    end
    @(posedge clk); #1;
    rdy_val = 1'b1;
    send(16'h1021, waited);
    check("resume_or", {o_Valid, o_ALUOp, o_AddrReg1, o_AddrReg2}, {1'b1, 4'd4, 3'd4, 3'd1});

    // Mode 11 word
    send(16'hC000, waited);
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    check("illegal_bundle", {o_Valid, o_Illegal, o_IllegalCnt, o_ALUOp, o_WriteBack},
          {1'b1, 1'b1, 8'd1, 4'd0, 1'b0});
    for (int i = 0; i < 299; i++) send({2'b11, 14'($urandom)}, waited);
    check("illegal_cnt_sat", 64'(o_IllegalCnt), 64'd255);
`else
    check("illegal_dropped", 64'(o_Valid), 64'd0);
    send(16'h4800, waited);
    check("illegal_dat_dropped", 64'(o_Valid), 64'd0);
`endif

    // Randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      w = 16'($urandom);
      if (r <= 5)      w[15:10] = {2'b00, 4'($urandom_range(0, 4))};
      else if (r <= 7) w[15:10] = {2'b01, 4'($urandom_range(0, 1))};
      else if (r == 8) w[15:10] = {2'b01, 4'($urandom_range(2, 15))};
      send(w, waited);
    end
    if (pend) send(16'($urandom), waited);
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("random_drain", 64'(exp_q.size()), 64'd0);

    // Reset while waiting for an immediate
    send(16'h4018, waited);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {o_Valid, cur_out()}, 64'd0);
    exp_q.delete();
    pend = 1'b0;
    ill_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0415, waited);
    check("post_reset_add", {o_Valid, o_ALUOp, o_UseImm, o_AddrReg1, o_AddrReg2, o_Imm},
          {1'b1, 4'd1, 1'b0, 3'd2, 3'd5, 16'd0});
    repeat (3) @(posedge clk);
    #1;
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
